// File: rtl/main_fsm.sv
// -----------------------------------------------------------------------------
// main_fsm -- multicycle control unit for the RV32I datapath.
//
// A Moore state machine that walks each instruction (lw, sw, R-type, I-type
// ALU, beq, jal) through fetch, decode, address, memory, execute and writeback
// steps. It drives the register enables and mux selects of the multicycle
// datapath from the opcode field held in the instruction register.
//
// Fetch, load and store each last 1 + MEM_WAIT cycles. A 4-bit wait counter
// runs inside those states, and the memory-side strobes (irWrite/pcUpdate in
// FETCH, memWrite in MEMWRITE) fire only on the final wait cycle.
//
// Build option:
//   MAIN_FSM_ILLEGAL_TRAP_EN  When defined, an unsupported opcode parks the FSM
//                             in HALT with `illegal` held high until reset.
//                             When undefined, the opcode is treated as a nop:
//                             `illegal` pulses for one cycle and the FSM
//                             fetches the next instruction.
//
// Parameters:
//   MEM_WAIT   extra wait cycles per memory access, legal range 0..15
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   op         opcode instr[6:0] from the instruction register
//   pcUpdate   unconditional PC write enable
//   branch     conditional PC write (the datapath ANDs it with zero)
//   regWrite   register file write enable
//   memWrite   data memory write enable
//   irWrite    instruction register / oldPC load enable
//   adrSrc     memory address select: 0 = PC, 1 = result
//   resultSrc  00 ALUOut, 01 Data, 10 ALUResult
//   aluSrcA    00 PC, 01 oldPC, 10 rs1 data
//   aluSrcB    00 rs2 data, 01 immExt, 10 constant 4
//   aluOp      00 add, 01 subtract/compare, 10 funct-decoded
//   immSrc     immediate format, combinational from op
//   illegal    unsupported-opcode flag (registered)
//   state      current state encoding, for debug
// -----------------------------------------------------------------------------
module main_fsm #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic       pcUpdate,
  output logic       branch,
  output logic       regWrite,
  output logic       memWrite,
  output logic       irWrite,
  output logic       adrSrc,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] immSrc,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Count value on the final cycle of a memory access.
  localparam logic [3:0] WAIT_LAST = MEM_WAIT[3:0];

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic       illegal_reg;
  logic       wait_done;

  assign wait_done = (cnt_reg == WAIT_LAST);

  // ---------------------------------------------------------------------------
  // State, wait counter and illegal flag.
  // The counter defaults to 0 every cycle and only advances while a memory
  // state is still waiting, so it is guaranteed to be 0 on entry to FETCH,
  // MEMREAD and MEMWRITE without tracking the entry edge explicitly.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      cnt_reg     <= 4'd0;
      illegal_reg <= 1'b0;
    end else begin
      cnt_reg     <= 4'd0;
      illegal_reg <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          if (wait_done) begin
            state_reg <= S_DECODE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end

        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_reg <= S_MEMADR;
            OP_R:         state_reg <= S_EXECUTER;
            OP_I:         state_reg <= S_EXECUTEI;
            OP_BEQ:       state_reg <= S_BEQ;
            OP_JAL:       state_reg <= S_JAL;
            default: begin
              illegal_reg <= 1'b1;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
              state_reg   <= S_HALT;
`else
              state_reg   <= S_FETCH;
`endif
            end
          endcase
        end

        // Only sw goes to MEMWRITE; anything else that slipped in after
        // DECODE is handled as a load, which never writes memory.
        S_MEMADR: begin
          if (op == OP_SW) begin
            state_reg <= S_MEMWRITE;
          end else begin
            state_reg <= S_MEMREAD;
          end
        end

        S_MEMREAD: begin
          if (wait_done) begin
            state_reg <= S_MEMWB;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end

        S_MEMWRITE: begin
          if (wait_done) begin
            state_reg <= S_FETCH;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end

        S_EXECUTER, S_EXECUTEI, S_JAL: state_reg <= S_ALUWB;

        S_MEMWB, S_ALUWB, S_BEQ: state_reg <= S_FETCH;

        S_HALT: begin
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
          // Parked until reset; keep the flag visible the whole time.
          state_reg   <= S_HALT;
          illegal_reg <= 1'b1;
`else
          state_reg   <= S_FETCH;
`endif
        end

        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode from the state register and the wait counter.
  // ---------------------------------------------------------------------------
  logic       pc_update_dec;
  logic       branch_dec;
  logic       reg_write_dec;
  logic       mem_write_dec;
  logic       ir_write_dec;

  always_comb begin
    pc_update_dec = 1'b0;
    branch_dec    = 1'b0;
    reg_write_dec = 1'b0;
    mem_write_dec = 1'b0;
    ir_write_dec  = 1'b0;
    adrSrc        = 1'b0;
    resultSrc     = 2'b00;
    aluSrcA       = 2'b00;
    aluSrcB       = 2'b00;
    aluOp         = 2'b00;
    case (state_reg)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but committed only once memory
        // has delivered the instruction.
        aluSrcB       = 2'b10;
        resultSrc     = 2'b10;
        ir_write_dec  = wait_done;
        pc_update_dec = wait_done;
      end
      S_DECODE: begin
        // Precompute oldPC + imm for a possible beq target.
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      S_MEMREAD: begin
        adrSrc = 1'b1;
      end
      S_MEMWB: begin
        resultSrc     = 2'b01;
        reg_write_dec = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc        = 1'b1;
        mem_write_dec = wait_done;
      end
      S_EXECUTER: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      S_EXECUTEI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
      end
      S_ALUWB: begin
        reg_write_dec = 1'b1;
      end
      S_BEQ: begin
        aluSrcA    = 2'b10;
        aluOp      = 2'b01;
        branch_dec = 1'b1;
      end
      S_JAL: begin
        // Link value oldPC + 4 goes to ALUOut while the jump target computed
        // in DECODE is written to the PC.
        aluSrcA       = 2'b01;
        aluSrcB       = 2'b10;
        pc_update_dec = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Reset masks every state-changing strobe immediately, so an instruction
  // aborted by reset cannot commit anything in the reset cycle itself.
  assign pcUpdate = pc_update_dec & ~reset;
  assign branch   = branch_dec    & ~reset;
  assign regWrite = reg_write_dec & ~reset;
  assign memWrite = mem_write_dec & ~reset;
  assign irWrite  = ir_write_dec  & ~reset;
  assign illegal  = illegal_reg   & ~reset;
  assign state    = reset ? 4'd0 : state_reg;

  // Immediate format follows the opcode directly so the extender is ready
  // in DECODE without waiting for a state change.
  always_comb begin
    case (op)
      OP_LW, OP_I: immSrc = 2'b00;
      OP_SW:       immSrc = 2'b01;
      OP_BEQ:      immSrc = 2'b10;
      OP_JAL:      immSrc = 2'b11;
      default:     immSrc = 2'b00;
    endcase
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control unit for the RV32I datapath: a Moore state machine that sequences fetch, decode, address, memory, execute and writeback steps for lw, sw, R-type, I-type ALU, beq and jal. It sits between the instruction register's opcode field and the multicycle datapath's register enables and mux selects. It is the successor of the single-cycle main decoder. It adds a parametrised memory wait-state counter and illegal-opcode detection.

## Interface
- `MEM_WAIT`, default 0: extra wait cycles per memory access (fetch, load, store); legal range 0..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  7  opcode, instr[6:0], from the instruction register.
- `pcUpdate`  out  1  PC write enable (unconditional).
- `branch`  out  1  conditional PC write; the datapath ANDs it with zero.
- `regWrite`  out  1  register file write enable.
- `memWrite`  out  1  data memory write enable.
- `irWrite`  out  1  instruction register / oldPC load enable.
- `adrSrc`  out  1  memory address: 0 = PC, 1 = result.
- `resultSrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- `aluSrcA`  out  2  00 PC, 01 oldPC, 10 rs1 data.
- `aluSrcB`  out  2  00 rs2 data, 01 immExt, 10 constant 4.
- `aluOp`  out  2  00 add, 01 subtract/compare, 10 funct-decoded.
- `immSrc`  out  2  combinational from `op`: 0000011/0010011 → 00, 0100011 → 01, 1100011 → 10, 1101111 → 11, any other value → 00.
- `illegal`  out  1  unsupported opcode flag.
- `state`  out  4  current state encoding, for debug.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, HALT 11.
- Default output values: all enables 0, all selects 00, `adrSrc` 0.
- Per-state outputs (anything not listed takes the default):
  - FETCH: aluSrcB=10, resultSrc=10; irWrite=1 and pcUpdate=1 on the last wait cycle only.
  - DECODE: aluSrcA=01, aluSrcB=01.
  - MEMADR: aluSrcA=10, aluSrcB=01.
  - MEMREAD: adrSrc=1.
  - MEMWB: resultSrc=01, regWrite=1.
  - MEMWRITE: adrSrc=1; memWrite=1 on the last wait cycle only.
  - EXECUTER: aluSrcA=10, aluOp=10.
  - EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10.
  - ALUWB: regWrite=1.
  - BEQ: aluSrcA=10, aluOp=01, branch=1.
  - JAL: aluSrcA=01, aluSrcB=10, pcUpdate=1.
- Transitions:
  - FETCH → DECODE once the wait count is done.
  - DECODE dispatches on `op`: lw/sw → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; any other value → illegal path (see Configuration).
  - MEMADR → MEMREAD for lw, MEMWRITE for sw (decided by `op`).
  - MEMREAD → MEMWB once the wait count is done.
  - MEMWRITE → FETCH once the wait count is done.
  - EXECUTER, EXECUTEI and JAL → ALUWB.
  - MEMWB, ALUWB and BEQ → FETCH.
- Wait counter:
  - Width is 4 bits.
  - Cleared on entry to FETCH, MEMREAD and MEMWRITE.
  - Increments each cycle spent in one of those states.
  - "Done" means count == MEM_WAIT.
  - With MEM_WAIT=0 each of those states lasts exactly 1 cycle.
- `op` is sampled only in DECODE and MEMADR. Changes in other states have no effect apart from the `immSrc` combinational path.

## Timing
- Outputs are Moore, decoded from the state register and the wait counter; there is no combinational path from `op` except `immSrc`.
- Instruction latency with W = MEM_WAIT:
  - lw: 5+2W cycles.
  - sw: 4+2W cycles.
  - R-type: 4+W cycles.
  - I-type: 4+W cycles.
  - jal: 4+W cycles.
  - beq: 3+W cycles.
- Reset:
  - Next edge: state=FETCH, counter=0.
  - While `reset` is high: pcUpdate, branch, regWrite, memWrite and irWrite are forced to 0; `illegal` is 0; `state` reads 0.
  - Reset asserted mid-instruction aborts it on the next edge; no partial write occurs after that edge.
- `illegal` is registered and asserts on the cycle after DECODE sees an unsupported `op`.

## Configuration
- `MAIN_FSM_ILLEGAL_TRAP_EN` defined:
  - An unsupported opcode in DECODE moves the FSM to HALT.
  - HALT has all outputs at their defaults and holds `illegal`=1.
  - HALT is left only by `reset`.
- `MAIN_FSM_ILLEGAL_TRAP_EN` not defined:
  - An unsupported opcode in DECODE returns to FETCH; the instruction is treated as a nop.
  - `illegal` pulses high for exactly 1 cycle (the FETCH cycle after DECODE).
  - HALT is unreachable.

## Test plan
- MEM_WAIT=0, reset, then op=0000011: state sequence 0,1,2,3,4,0. regWrite=1 only in state 4. irWrite and pcUpdate are 1 in each FETCH cycle.
- MEM_WAIT=2, op=0100011: FETCH lasts 3 cycles with irWrite=1 only in the 3rd. MEMWRITE lasts 3 cycles with memWrite=1 only in the 3rd. Total 8 cycles.
- MEM_WAIT=0, op=1100011 then 1101111: beq takes states 0,1,10 with branch=1 and aluOp=01 in state 10. jal takes states 0,1,9,7 with pcUpdate=1 in 9 and regWrite=1 in 7.
- MEM_WAIT=0, op=0110011 then 0010011: states 0,1,6,7 with aluSrcB=00, then states 0,1,8,7 with aluSrcB=01. aluOp=10 in states 6 and 8.
- op=1111111:
  - Trap build: state=11 and `illegal`=1 held for 10 cycles; reset returns to state 0 with `illegal`=0.
  - Non-trap build: `illegal` high for 1 cycle, state back to 0.
- MEM_WAIT=1, reset asserted during MEMREAD of lw: next state 0, regWrite never asserts, counter restarts at 0.
